// File: rtl/mipi_rx_pkg.sv
// Shared types and constants for the MIPI D-PHY HS receive path.
// Used by the byte aligner, sync detector and lane merger.
package mipi_rx_pkg;

    localparam int                     MIPI_BYTE_W    = 8;
    localparam logic [MIPI_BYTE_W-1:0] MIPI_SYNC_BYTE = 8'hB8;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        HUNT,
        LOCKED,
        ERR
    } mipi_rx_state_e;

    // Byte starting at bit 'off' of a two-word window; bit 0 is the earliest received.
    function automatic logic [MIPI_BYTE_W-1:0] mipi_extract_byte(
        input logic [2*MIPI_BYTE_W-1:0] win,
        input logic [2:0]               off
    );
        logic [2*MIPI_BYTE_W-1:0] shifted;
        shifted = win >> off;
        return shifted[MIPI_BYTE_W-1:0];
    endfunction

endpackage

// File: rtl/mipi_sync_detect.sv
// Searches a 16-bit window for the HS sync byte at all 8 bit offsets.
// Reports whether any offset matched and the lowest matching offset.
module mipi_sync_detect
    import mipi_rx_pkg::*;
#(
    parameter logic [MIPI_BYTE_W-1:0] SYNC_BYTE = MIPI_SYNC_BYTE
) (
    input  logic [2*MIPI_BYTE_W-1:0] win,
    output logic                     found,
    output logic [2:0]               offset
);

    logic [7:0] match;

    always_comb begin
        match = '0;
        for (int k = 0; k < 8; k++) begin
            match[k] = (mipi_extract_byte(win, 3'(k)) == SYNC_BYTE);
        end
    end

    // Scan downward so the lowest matching offset is the one left standing.
    always_comb begin
        found  = |match;
        offset = 3'd0;
        for (int k = 7; k >= 0; k--) begin
            if (match[k]) begin
                offset = 3'(k);
            end
        end
    end

endmodule

// File: rtl/mipi_hs_byte_aligner.sv
// Locks onto the D-PHY HS sync byte in a bit-aligned IOD lane and emits
// byte-aligned payload with valid / start-of-transmission markers.
//   state  | meaning
//   IDLE   | lane in LP or bit alignment not done
//   SETTLE | ignoring HS_SETTLE words after LP exit
//   HUNT   | searching all 8 offsets for the sync byte
//   LOCKED | extracting payload at the locked offset
//   ERR    | hunt timed out, waiting for LP
module mipi_hs_byte_aligner
    import mipi_rx_pkg::*;
#(
    parameter logic [MIPI_BYTE_W-1:0] SYNC_BYTE    = MIPI_SYNC_BYTE,
    parameter int                     HS_SETTLE    = 4,
    parameter int                     SYNC_TIMEOUT = 32
) (
    input  logic                   SCLK,
    input  logic                   RESET,
    input  logic                   BIT_ALGN_DONE,
    input  logic                   LP_IN,
    input  logic [MIPI_BYTE_W-1:0] RX_DATA,
    output logic [MIPI_BYTE_W-1:0] BYTE_DATA,
    output logic                   BYTE_VALID,
    output logic                   BYTE_SOT,
    output logic                   ALIGN_LOCKED,
    output logic [2:0]             ALIGN_OFFSET,
    output logic                   SYNC_ERR,
    output logic [7:0]             SYNC_ERR_CNT
);

    localparam int SET_W  = (HS_SETTLE > 0) ? $clog2(HS_SETTLE + 1) : 1;
    localparam int HUNT_W = $clog2(SYNC_TIMEOUT + 1);

    mipi_rx_state_e            state_q, state_d;
    logic [SET_W-1:0]          settle_cnt_q, settle_cnt_d;
    logic [HUNT_W-1:0]         hunt_cnt_q, hunt_cnt_d;
    logic [MIPI_BYTE_W-1:0]    prev_q, prev_d;
    logic [MIPI_BYTE_W-1:0]    byte_data_q, byte_data_d;
    logic                      byte_valid_q, byte_valid_d;
    logic                      byte_sot_q, byte_sot_d;
    logic                      first_q, first_d;
    logic                      align_locked_q, align_locked_d;
    logic [2:0]                align_offset_q, align_offset_d;
    logic                      sync_err_q, sync_err_d;
    logic [7:0]                sync_err_cnt_q, sync_err_cnt_d;

    logic [2*MIPI_BYTE_W-1:0]  win;
    logic                      det_found;
    logic [2:0]                det_offset;

    assign win = {RX_DATA, prev_q};

    mipi_sync_detect #(
        .SYNC_BYTE (SYNC_BYTE)
    ) u_sync_detect (
        .win    (win),
        .found  (det_found),
        .offset (det_offset)
    );

    always_comb begin
        state_d        = state_q;
        settle_cnt_d   = settle_cnt_q;
        hunt_cnt_d     = hunt_cnt_q;
        prev_d         = RX_DATA;
        byte_data_d    = byte_data_q;
        byte_valid_d   = 1'b0;
        byte_sot_d     = 1'b0;
        first_d        = first_q;
        align_offset_d = align_offset_q;
        sync_err_d     = 1'b0;
        sync_err_cnt_d = sync_err_cnt_q;

        // Losing bit alignment or returning to LP abandons the current window.
        if (!BIT_ALGN_DONE) begin
            state_d = IDLE;
        end else if (LP_IN && (state_q != IDLE)) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (!LP_IN) begin
                        if (HS_SETTLE == 0) begin
                            state_d    = HUNT;
                            hunt_cnt_d = HUNT_W'(1);
                        end else begin
                            state_d      = SETTLE;
                            settle_cnt_d = SET_W'(1);
                        end
                    end
                end
                SETTLE: begin
                    if (settle_cnt_q == SET_W'(HS_SETTLE)) begin
                        state_d    = HUNT;
                        hunt_cnt_d = HUNT_W'(1);
                    end else begin
                        settle_cnt_d = settle_cnt_q + 1'b1;
                    end
                end
                HUNT: begin
                    if (det_found) begin
                        state_d        = LOCKED;
                        align_offset_d = det_offset;
                        first_d        = 1'b1;
                    end else if (hunt_cnt_q == HUNT_W'(SYNC_TIMEOUT)) begin
                        state_d    = ERR;
                        sync_err_d = 1'b1;
                        if (sync_err_cnt_q != 8'hFF) begin
                            sync_err_cnt_d = sync_err_cnt_q + 8'd1;
                        end
                    end else begin
                        hunt_cnt_d = hunt_cnt_q + 1'b1;
                    end
                end
                LOCKED: begin
                    byte_data_d  = mipi_extract_byte(win, align_offset_q);
                    byte_valid_d = 1'b1;
                    byte_sot_d   = first_q;
                    first_d      = 1'b0;
                end
                ERR: begin
                    state_d = ERR;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        align_locked_d = (state_d == LOCKED);
    end

    always_ff @(posedge SCLK) begin
        if (RESET) begin
            state_q        <= IDLE;
            settle_cnt_q   <= '0;
            hunt_cnt_q     <= '0;
            prev_q         <= '0;
            byte_data_q    <= '0;
            byte_valid_q   <= 1'b0;
            byte_sot_q     <= 1'b0;
            first_q        <= 1'b0;
            align_locked_q <= 1'b0;
            align_offset_q <= 3'd0;
            sync_err_q     <= 1'b0;
            sync_err_cnt_q <= 8'd0;
        end else begin
            state_q        <= state_d;
            settle_cnt_q   <= settle_cnt_d;
            hunt_cnt_q     <= hunt_cnt_d;
            prev_q         <= prev_d;
            byte_data_q    <= byte_data_d;
            byte_valid_q   <= byte_valid_d;
            byte_sot_q     <= byte_sot_d;
            first_q        <= first_d;
            align_locked_q <= align_locked_d;
            align_offset_q <= align_offset_d;
            sync_err_q     <= sync_err_d;
            sync_err_cnt_q <= sync_err_cnt_d;
        end
    end

    assign BYTE_DATA    = byte_data_q;
    assign BYTE_VALID   = byte_valid_q;
    assign BYTE_SOT     = byte_sot_q;
    assign ALIGN_LOCKED = align_locked_q;
    assign ALIGN_OFFSET = align_offset_q;
    assign SYNC_ERR     = sync_err_q;
    assign SYNC_ERR_CNT = sync_err_cnt_q;

endmodule

// File: tb/tb_mipi_hs_byte_aligner.sv
// Directed bench for the HS byte aligner: offset lock, latency, timeout,
// LP / alignment-loss exits, reset and error-counter saturation.
module tb_mipi_hs_byte_aligner;

    localparam int HS_SETTLE    = 4;
    localparam int SYNC_TIMEOUT = 32;

    logic       SCLK = 1'b0;
    logic       RESET = 1'b1;
    logic       BIT_ALGN_DONE = 1'b0;
    logic       LP_IN = 1'b1;
    logic [7:0] RX_DATA = 8'h00;
    logic [7:0] BYTE_DATA;
    logic       BYTE_VALID;
    logic       BYTE_SOT;
    logic       ALIGN_LOCKED;
    logic [2:0] ALIGN_OFFSET;
    logic       SYNC_ERR;
    logic [7:0] SYNC_ERR_CNT;

    int n_checks = 0;
    int n_errors = 0;
    logic valid_seen;

    mipi_hs_byte_aligner #(
        .SYNC_BYTE    (8'hB8),
        .HS_SETTLE    (HS_SETTLE),
        .SYNC_TIMEOUT (SYNC_TIMEOUT)
    ) dut (
        .SCLK          (SCLK),
        .RESET         (RESET),
        .BIT_ALGN_DONE (BIT_ALGN_DONE),
        .LP_IN         (LP_IN),
        .RX_DATA       (RX_DATA),
        .BYTE_DATA     (BYTE_DATA),
        .BYTE_VALID    (BYTE_VALID),
        .BYTE_SOT      (BYTE_SOT),
        .ALIGN_LOCKED  (ALIGN_LOCKED),
        .ALIGN_OFFSET  (ALIGN_OFFSET),
        .SYNC_ERR      (SYNC_ERR),
        .SYNC_ERR_CNT  (SYNC_ERR_CNT)
    );

    always #5 SCLK = ~SCLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge SCLK);
        #1;
    endtask

    task automatic drive(input logic done, input logic lp, input logic [7:0] d);
        BIT_ALGN_DONE = done;
        LP_IN         = lp;
        RX_DATA       = d;
        tick();
    endtask

    // LP cycle, LP-exit cycle, then HS_SETTLE ignored words: next drive is hunt cycle 1.
    task automatic enter_hunt();
        drive(1'b1, 1'b1, 8'h00);
        drive(1'b1, 1'b0, 8'h00);
        repeat (HS_SETTLE) drive(1'b1, 1'b0, 8'h00);
    endtask

    initial begin
        tick();
        tick();
        RESET = 1'b0;

        chk("rst_data",   32'(BYTE_DATA),    32'h00);
        chk("rst_valid",  32'(BYTE_VALID),   32'h0);
        chk("rst_locked", 32'(ALIGN_LOCKED), 32'h0);
        chk("rst_errcnt", 32'(SYNC_ERR_CNT), 32'h0);

        // Offset 0: 00 B8 12 34 56
        enter_hunt();
        drive(1'b1, 1'b0, 8'h00);
        drive(1'b1, 1'b0, 8'hB8);
        drive(1'b1, 1'b0, 8'h12);
        chk("o0_locked",     32'(ALIGN_LOCKED), 32'h1);
        chk("o0_offset",     32'(ALIGN_OFFSET), 32'h0);
        chk("o0_valid_t1",   32'(BYTE_VALID),   32'h0);
        drive(1'b1, 1'b0, 8'h34);
        chk("o0_b0_data",    32'(BYTE_DATA),    32'h12);
        chk("o0_b0_valid",   32'(BYTE_VALID),   32'h1);
        chk("o0_b0_sot",     32'(BYTE_SOT),     32'h1);
        drive(1'b1, 1'b0, 8'h56);
        chk("o0_b1_data",    32'(BYTE_DATA),    32'h34);
        chk("o0_b1_valid",   32'(BYTE_VALID),   32'h1);
        chk("o0_b1_sot",     32'(BYTE_SOT),     32'h0);

        // LP exit while locked: the LP window is dropped
        drive(1'b1, 1'b1, 8'h78);
        chk("lp0_valid",     32'(BYTE_VALID),   32'h0);
        chk("lp0_locked",    32'(ALIGN_LOCKED), 32'h0);

        // Offset 3: stream 00 B8 12 34 delayed 3 bits -> words 00 C0 95 A0 01
        enter_hunt();
        drive(1'b1, 1'b0, 8'h00);
        drive(1'b1, 1'b0, 8'hC0);
        drive(1'b1, 1'b0, 8'h95);
        chk("o3_locked",     32'(ALIGN_LOCKED), 32'h1);
        chk("o3_offset",     32'(ALIGN_OFFSET), 32'h3);
        chk("o3_valid_t1",   32'(BYTE_VALID),   32'h0);
        drive(1'b1, 1'b0, 8'hA0);
        chk("o3_b0_data",    32'(BYTE_DATA),    32'h12);
        chk("o3_b0_sot",     32'(BYTE_SOT),     32'h1);
        drive(1'b1, 1'b0, 8'h01);
        chk("o3_b1_data",    32'(BYTE_DATA),    32'h34);
        chk("o3_b1_valid",   32'(BYTE_VALID),   32'h1);
        chk("o3_b1_sot",     32'(BYTE_SOT),     32'h0);
        drive(1'b1, 1'b1, 8'h00);
        chk("lp3_valid",     32'(BYTE_VALID),   32'h0);
        chk("lp3_locked",    32'(ALIGN_LOCKED), 32'h0);
        chk("lp3_offset",    32'(ALIGN_OFFSET), 32'h3);

        // Hunt timeout with idle data
        enter_hunt();
        valid_seen = 1'b0;
        for (int i = 0; i < SYNC_TIMEOUT - 1; i++) begin
            drive(1'b1, 1'b0, 8'h00);
            valid_seen = valid_seen | BYTE_VALID;
        end
        chk("to_err_early",  32'(SYNC_ERR),     32'h0);
        drive(1'b1, 1'b0, 8'h00);
        chk("to_err_pulse",  32'(SYNC_ERR),     32'h1);
        chk("to_err_cnt",    32'(SYNC_ERR_CNT), 32'h1);
        drive(1'b1, 1'b0, 8'h00);
        valid_seen = valid_seen | BYTE_VALID;
        chk("to_err_1cyc",   32'(SYNC_ERR),     32'h0);
        chk("to_no_valid",   32'(valid_seen),   32'h0);
        chk("to_not_locked", 32'(ALIGN_LOCKED), 32'h0);

        // Recovery after LP
        enter_hunt();
        drive(1'b1, 1'b0, 8'hB8);
        drive(1'b1, 1'b0, 8'h12);
        chk("rc_locked",     32'(ALIGN_LOCKED), 32'h1);
        chk("rc_offset",     32'(ALIGN_OFFSET), 32'h0);
        drive(1'b1, 1'b0, 8'h34);
        chk("rc_b0_data",    32'(BYTE_DATA),    32'h12);
        chk("rc_b0_sot",     32'(BYTE_SOT),     32'h1);

        // Match on the final hunt cycle beats the timeout
        enter_hunt();
        for (int i = 0; i < SYNC_TIMEOUT - 2; i++) drive(1'b1, 1'b0, 8'h00);
        drive(1'b1, 1'b0, 8'hB8);
        drive(1'b1, 1'b0, 8'h12);
        chk("last_locked",   32'(ALIGN_LOCKED), 32'h1);
        chk("last_no_err",   32'(SYNC_ERR),     32'h0);
        drive(1'b1, 1'b0, 8'h34);
        chk("last_errcnt",   32'(SYNC_ERR_CNT), 32'h1);
        chk("last_b0_data",  32'(BYTE_DATA),    32'h12);
        chk("last_b0_sot",   32'(BYTE_SOT),     32'h1);

        // Loss of bit alignment while locked
        drive(1'b0, 1'b0, 8'h56);
        chk("bad_valid",     32'(BYTE_VALID),   32'h0);
        chk("bad_locked",    32'(ALIGN_LOCKED), 32'h0);
        drive(1'b0, 1'b0, 8'hB8);
        drive(1'b0, 1'b0, 8'h12);
        chk("bad_no_hunt",   32'(ALIGN_LOCKED), 32'h0);

        // Reset mid-packet at offset 3
        enter_hunt();
        drive(1'b1, 1'b0, 8'h00);
        drive(1'b1, 1'b0, 8'hC0);
        drive(1'b1, 1'b0, 8'h95);
        drive(1'b1, 1'b0, 8'hA0);
        chk("pre_rst_valid", 32'(BYTE_VALID),   32'h1);
        RESET = 1'b1;
        drive(1'b1, 1'b0, 8'h01);
        chk("mrst_data",     32'(BYTE_DATA),    32'h00);
        chk("mrst_valid",    32'(BYTE_VALID),   32'h0);
        chk("mrst_sot",      32'(BYTE_SOT),     32'h0);
        chk("mrst_locked",   32'(ALIGN_LOCKED), 32'h0);
        chk("mrst_offset",   32'(ALIGN_OFFSET), 32'h0);
        chk("mrst_err",      32'(SYNC_ERR),     32'h0);
        chk("mrst_errcnt",   32'(SYNC_ERR_CNT), 32'h0);
        RESET = 1'b0;

        // 256 forced timeouts saturate the counter at 255
        for (int n = 1; n <= 256; n++) begin
            enter_hunt();
            repeat (SYNC_TIMEOUT) drive(1'b1, 1'b0, 8'h00);
            if (n == 1)   chk("sat_cnt_1",   32'(SYNC_ERR_CNT), 32'd1);
            if (n == 255) chk("sat_cnt_255", 32'(SYNC_ERR_CNT), 32'd255);
        end
        chk("sat_cnt_256",   32'(SYNC_ERR_CNT), 32'd255);
        chk("sat_err_pulse", 32'(SYNC_ERR),     32'h1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
